regfile_writeback: RTL and testbench

- Register file plus writeback buffer at the consumer end of the control unit's write_enable signal.
- The execute stage presents results with a valid/ready handshake. Each result is buffered in a 2-entry FIFO and committed to the register array one per cycle.
- A per-register busy scoreboard tracks pending producers.
- Two combinational read ports return the newest value of each register, bypassing from the FIFO, plus that register's busy flag.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_writeback_wb_fifo.sv | 67 ++++++
 rtl/regfile_writeback.sv | 118 +++++++++++
 tb/tb_regfile_writeback.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file writeback slice.
package regfile_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH = 2;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned ZERO_REG   = 0;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// Two-entry writeback FIFO; exposes head for draining and both entries,
// ordered by age, for read bypass.
module wb_fifo #(
  parameter type entry_t = regfile_pkg::wb_entry_t
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  entry_t     push_entry,
  input  logic       pop,
  output logic [1:0] count,
  output entry_t     head,
  output entry_t     young,
  output logic       young_vld,
  output entry_t     old,
  output logic       old_vld
);

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Youngest entry sits just behind the write pointer; when full, the
  // write pointer has caught up with the oldest entry.
  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];
  assign young     = mem_q[~wr_ptr_q];
  assign young_vld = (count_q != 2'd0);
  assign old       = mem_q[wr_ptr_q];
  assign old_vld   = (count_q == 2'd2);

endmodule

// File: rtl/regfile_writeback.sv
// Register file with a 2-entry writeback buffer, busy scoreboard and two
// combinational read ports that bypass from buffered writes.
module regfile_writeback #(
  parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int unsigned FIFO_DEPTH = regfile_pkg::FIFO_DEPTH,
  parameter int unsigned NUM_REGS   = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  hold,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic                  rd_busy_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  rd_busy_b,
  output logic [NUM_REGS-1:0]   busy_vector,
  output logic [1:0]            fifo_count
);

  import regfile_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] R0 = ADDR_WIDTH'(ZERO_REG);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t     push_entry, head, young, old;
  logic       young_vld, old_vld;
  logic [1:0] count;
  logic       accept, drain;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]                 busy_q, busy_d;

  assign wb_ready   = (count != 2'd2);
  assign accept     = wb_valid && wb_ready;
  assign drain      = !hold && (count != 2'd0);
  assign push_entry = '{we: write_enable, addr: wb_addr, data: wb_data};

  wb_fifo #(
    .entry_t(entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (accept),
    .push_entry(push_entry),
    .pop       (drain),
    .count     (count),
    .head      (head),
    .young     (young),
    .young_vld (young_vld),
    .old       (old),
    .old_vld   (old_vld)
  );

  always_comb begin
    regs_d = regs_q;
    if (drain && head.we && (head.addr != R0)) begin
      regs_d[head.addr] = head.data;
    end
  end

  // Clear-on-accept is applied first so a same-edge issue to that register wins.
  always_comb begin
    busy_d = busy_q;
    if (accept) begin
      busy_d[wb_addr] = 1'b0;
    end
    if (issue_valid && (issue_addr != R0)) begin
      busy_d[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] a);
    if (a == R0) begin
      return '0;
    end else if (young_vld && young.we && (young.addr == a)) begin
      return young.data;
    end else if (old_vld && old.we && (old.addr == a)) begin
      return old.data;
    end else begin
      return regs_q[a];
    end
  endfunction

  always_comb begin
    rd_data_a = read_port(rd_addr_a);
    rd_data_b = read_port(rd_addr_b);
  end

  assign rd_busy_a   = busy_q[rd_addr_a];
  assign rd_busy_b   = busy_q[rd_addr_b];
  assign busy_vector = busy_q;
  assign fifo_count  = count;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_regfile_writeback;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wb_valid, wb_ready, write_enable, hold, issue_valid;
  logic [AW-1:0] wb_addr, issue_addr, rd_addr_a, rd_addr_b;
  logic [DW-1:0] wb_data, rd_data_a, rd_data_b;
  logic          rd_busy_a, rd_busy_b;
  logic [NR-1:0] busy_vector;
  logic [1:0]    fifo_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  regfile_writeback #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .write_enable(write_enable),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .hold        (hold),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .rd_addr_a   (rd_addr_a),
    .rd_data_a   (rd_data_a),
    .rd_busy_a   (rd_busy_a),
    .rd_addr_b   (rd_addr_b),
    .rd_data_b   (rd_data_b),
    .rd_busy_b   (rd_busy_b),
    .busy_vector (busy_vector),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  // Reference model: buffered writes as a queue, oldest at the front.
  typedef struct {
    bit          we;
    bit [AW-1:0] addr;
    bit [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  logic [DW-1:0] mregs [NR];
  logic [NR-1:0] mbusy;

  function automatic void model_clear();
    mq.delete();
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    mbusy = '0;
  endfunction

  function automatic logic [DW-1:0] mdl_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].we && mq[i].addr == a) return mq[i].data;
    return mregs[a];
  endfunction

  initial model_clear();

  always @(negedge reset_n) model_clear();

  always @(posedge clk) begin
    if (!reset_n) begin
      model_clear();
    end else begin
      bit   acc;
      ent_t e;
      acc = wb_valid && (mq.size() < 2);
      if (!hold && mq.size() > 0) begin
        e = mq.pop_front();
        if (e.we && e.addr != 0) mregs[e.addr] = e.data;
      end
      if (acc) begin
        e.we = write_enable; e.addr = wb_addr; e.data = wb_data;
        mq.push_back(e);
        mbusy[wb_addr] = 1'b0;
      end
      if (issue_valid && issue_addr != 0) mbusy[issue_addr] = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, after inputs have settled.
  always @(negedge clk) begin
    #2;
    if (cmp_en) begin
      chk("wb_ready",    32'(wb_ready),    32'(mq.size() < 2));
      chk("fifo_count",  32'(fifo_count),  32'(mq.size()));
      chk("busy_vector", 32'(busy_vector), 32'(mbusy));
      chk("rd_data_a",   32'(rd_data_a),   32'(mdl_read(rd_addr_a)));
      chk("rd_data_b",   32'(rd_data_b),   32'(mdl_read(rd_addr_b)));
      chk("rd_busy_a",   32'(rd_busy_a),   32'(mbusy[rd_addr_a]));
      chk("rd_busy_b",   32'(rd_busy_b),   32'(mbusy[rd_addr_b]));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic put(input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_valid = v; write_enable = we; wb_addr = a; wb_data = d;
  endtask

  task automatic idle();
    wb_valid = 0; issue_valid = 0;
  endtask

  initial begin
    reset_n = 0; hold = 0; idle(); put(0, 0, 0, 0);
    issue_addr = 0; rd_addr_a = 0; rd_addr_b = 0;
    repeat (3) tick();
    reset_n = 1;
    cmp_en = 1;
    #2;
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ready", 32'(wb_ready), 1);
    chk("rst_busy",  32'(busy_vector), 0);

    // Basic write with bypass then commit
    tick(); put(1, 1, 2, 8'h5A); rd_addr_a = 2;
    tick(); idle();
    #2;
    chk("basic_bypass", 32'(rd_data_a), 32'h5A);
    chk("basic_count1", 32'(fifo_count), 1);
    chk("model_bypass", 32'(mdl_read(2)), 32'h5A);
    tick();
    #2;
    chk("basic_array",  32'(rd_data_a), 32'h5A);
    chk("basic_count0", 32'(fifo_count), 0);

    // Suppressed write clears busy but leaves the register alone
    tick(); put(1, 1, 1, 8'h11);
    tick(); idle(); issue_valid = 1; issue_addr = 1;
    tick(); idle(); rd_addr_a = 1;
    #2;
    chk("supp_busy_set", 32'(busy_vector[1]), 1);
    chk("supp_pre",      32'(rd_data_a), 32'h11);
    #(-2 + 2);
    put(1, 0, 1, 8'hFF);
    tick(); idle();
    #2;
    chk("supp_busy_clr", 32'(busy_vector[1]), 0);
    chk("supp_nobypass", 32'(rd_data_a), 32'h11);
    tick();
    #2;
    chk("supp_after", 32'(rd_data_a), 32'h11);

    // Backpressure under hold
    tick(); hold = 1; put(1, 1, 1, 8'hA1);
    tick(); put(1, 1, 2, 8'hA2);
    tick(); put(1, 1, 3, 8'hA3); rd_addr_a = 1; rd_addr_b = 2;
    #2;
    chk("bp_count2", 32'(fifo_count), 2);
    chk("bp_ready0", 32'(wb_ready), 0);
    chk("bp_rd1",    32'(rd_data_a), 32'hA1);
    chk("bp_rd2",    32'(rd_data_b), 32'hA2);
    tick();
    #2;
    chk("bp_stall_count", 32'(fifo_count), 2);
    hold = 0;
    tick();
    #2;
    chk("bp_drain1_count", 32'(fifo_count), 1);
    chk("bp_drain1_ready", 32'(wb_ready), 1);
    chk("bp_drain1_rd1",   32'(rd_data_a), 32'hA1);
    tick(); idle(); rd_addr_a = 3;
    #2;
    chk("bp_third_count", 32'(fifo_count), 1);
    chk("bp_third_rd",    32'(rd_data_a), 32'hA3);
    tick();
    #2;
    chk("bp_empty", 32'(fifo_count), 0);

    // Youngest buffered write wins; register 0 stays zero and never busy
    tick(); hold = 1; put(1, 1, 3, 8'h10);
    tick(); put(1, 1, 3, 8'h20);
    tick(); idle(); rd_addr_a = 3;
    #2;
    chk("prio_rd",    32'(rd_data_a), 32'h20);
    chk("prio_model", 32'(mdl_read(3)), 32'h20);
    hold = 0;
    tick(); tick();
    #2;
    chk("prio_array", 32'(rd_data_a), 32'h20);
    put(1, 1, 0, 8'h77); issue_valid = 1; issue_addr = 0; rd_addr_a = 0;
    tick(); idle();
    #2;
    chk("r0_read", 32'(rd_data_a), 0);
    chk("r0_busy", 32'(busy_vector), 0);
    tick();

    // Issue and accept to the same register on one edge: set wins
    put(1, 1, 2, 8'h33); issue_valid = 1; issue_addr = 2;
    tick(); idle();
    #2;
    chk("conflict_busy", 32'(busy_vector), 32'b0100);
    tick();

    // Reset with two entries buffered
    hold = 1; issue_valid = 1; issue_addr = 3; put(1, 1, 1, 8'h44);
    tick(); issue_valid = 0; put(1, 1, 2, 8'h55);
    tick(); idle();
    #2;
    chk("prerst_count", 32'(fifo_count), 2);
    chk("prerst_busy",  32'(busy_vector), 32'b1000);
    reset_n = 0;
    #1;
    chk("midrst_count", 32'(fifo_count), 0);
    chk("midrst_ready", 32'(wb_ready), 1);
    chk("midrst_busy",  32'(busy_vector), 0);
    for (int i = 0; i < NR; i++) begin
      rd_addr_a = AW'(i);
      #1;
      chk("midrst_read", 32'(rd_data_a), 0);
    end
    tick(); reset_n = 1; hold = 0;

    // Random traffic, model-checked every cycle
    for (int n = 0; n < 3000; n++) begin
      tick();
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 0;
        tick();
        reset_n = 1;
      end
      put($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
          AW'($urandom_range(0, NR - 1)), DW'($urandom));
      hold        = ($urandom_range(0, 3) == 0);
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_addr  = AW'($urandom_range(0, NR - 1));
      rd_addr_a   = AW'($urandom_range(0, NR - 1));
      rd_addr_b   = AW'($urandom_range(0, NR - 1));
    end
    tick(); idle();
    tick();
    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
